// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte).
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        CHK   = 3'd4,
        RUN   = 3'd5,
        ERROR = 3'd6
    } state_t;

    // A load is in progress (and bytes are accepted) in LEN0..CHK.
    function automatic logic is_busy(input state_t s);
        return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the program loader.
// Handshake: a byte moves on a rising clk edge iff rx_valid && rx_ready; the source
// holds rx_byte stable while rx_valid is high and the loader has not accepted it.
interface program_loader_if #(
    parameter int ADDR_W = 6
);
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Host side: supplies bytes, observes memory writes.
    modport master (
        output rx_valid, rx_byte,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side.
    modport slave (
        input  rx_valid, rx_byte,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/byte_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; word/word_ready appear the
// cycle after the fourth byte is taken. Clearing drops any partial word.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  idx;
    logic [23:0] pack;

    assign last_byte = (idx == 2'(BYTES_PER_WORD - 1));

    // Byte index, partial-word packing and the registered completed word.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= 2'd0;
            pack       <= 24'd0;
            word       <= 32'd0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (clear) begin
                idx  <= 2'd0;
                pack <= 24'd0;
            end else if (take) begin
                if (last_byte) begin
                    word       <= {byte_in, pack};
                    word_ready <= 1'b1;
                    idx        <= 2'd0;
                    pack       <= 24'd0;
                end else begin
                    case (idx)
                        2'd0:    pack[7:0]   <= byte_in;
                        2'd1:    pack[15:8]  <= byte_in;
                        default: pack[23:16] <= byte_in;
                    endcase
                    idx <= idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: holds the CPU in reset, receives LEN (16-bit word count)
// and LEN*4 data bytes, writes words to instruction memory from address 0, then
// releases the CPU. Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    program_loader_if.slave bus,
    output logic            cpu_reset,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [ADDR_W:0] word_count,
    output state_t          state
);

    localparam int               DEPTH     = 2 ** ADDR_W;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [ADDR_W:0]  CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            next_state;
    logic              take;
    logic              start_ok;
    logic              data_take;
    logic              data_last;
    logic              asm_last;
    logic              asm_ready;
    logic [31:0]       asm_word;
    logic [7:0]        len_lo;
    logic [LEN_W-1:0]  len_full;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] addr_q;

    assign bus.rx_ready = is_busy(state);
    assign take         = bus.rx_valid && bus.rx_ready;
    // start is only honoured when no load is running.
    assign start_ok     = start && !is_busy(state);
    assign data_take    = take && (state == DATA);
    // word_count equals the index of the word currently being assembled.
    assign data_last    = data_take && asm_last && (word_count == len_q - CNT_ONE);
    assign len_full     = {bus.rx_byte, len_lo};

    assign busy = is_busy(state);
    assign done = (state == RUN);
    assign err  = (state == ERROR);

    assign bus.imem_we    = asm_ready;
    assign bus.imem_wdata = asm_word;
    assign bus.imem_addr  = addr_q;

    byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .take       (data_take),
        .byte_in    (bus.rx_byte),
        .last_byte  (asm_last),
        .word       (asm_word),
        .word_ready (asm_ready)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR over data bytes only, restarted with each load.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= 8'd0;
        end else if (start_ok) begin
            csum <= 8'd0;
        end else if (data_take) begin
            csum <= csum ^ bus.rx_byte;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, RUN, ERROR: begin
                if (start) next_state = LEN0;
            end
            LEN0: begin
                if (take) next_state = LEN1;
            end
            LEN1: begin
                if (take) begin
                    if (len_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = CHK;
`else
                        next_state = RUN;
`endif
                    end else if (len_full > DEPTH_LEN) begin
                        next_state = ERROR;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (data_last) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state = CHK;
`else
                    next_state = RUN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (take) next_state = (bus.rx_byte == csum) ? RUN : ERROR;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Length capture, word counter and write address. The counter advances when a
    // word completes so it matches imem_we in the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo     <= 8'd0;
            len_q      <= '0;
            word_count <= '0;
            addr_q     <= '0;
        end else if (start_ok) begin
            word_count <= '0;
        end else begin
            if ((state == LEN0) && take) len_lo <= bus.rx_byte;
            if ((state == LEN1) && take) len_q  <= len_full[ADDR_W:0];
            if (data_take && asm_last) begin
                addr_q     <= word_count[ADDR_W-1:0];
                word_count <= word_count + CNT_ONE;
            end
        end
    end

    // CPU reset is registered from the state so release lands one cycle after the
    // final write; a restart from RUN reasserts it on the very next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset <= 1'b1;
        end else begin
            cpu_reset <= !((state == RUN) && !start);
        end
    end

endmodule
